// File: rtl/tqvp_sprite_pkg.sv
// Shared constants for the TinyQV sprite engine: register map, field positions, FSM encoding.
package tqvp_sprite_pkg;

    // Register byte offsets
    localparam logic [5:0] ADDR_CTRL     = 6'h00;
    localparam logic [5:0] ADDR_STATUS   = 6'h04;
    localparam logic [5:0] ADDR_PAT_PTR  = 6'h08;
    localparam logic [5:0] ADDR_PAT_DATA = 6'h0C;
    localparam logic [5:0] ADDR_SPR_BASE = 6'h10;

    // CTRL / STATUS bit positions
    localparam int unsigned CTRL_ENABLE_BIT = 0;
    localparam int unsigned CTRL_IRQ_EN_BIT = 1;
    localparam int unsigned CTRL_MASK_LSB   = 8;
    localparam int unsigned STATUS_COLL_BIT = 0;
    localparam int unsigned STATUS_BUSY_BIT = 1;

    // PAT_PTR and SPRn field positions
    localparam int unsigned PTR_ROW_LSB = 0;
    localparam int unsigned PTR_ID_LSB  = 8;
    localparam int unsigned SPR_Y_LSB   = 16;
    localparam int unsigned SPR_COL_LSB = 28;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StScan   = 2'd1,
        StCommit = 2'd2
    } scan_state_e;

endpackage

// File: rtl/sprite_hit_unit.sv
// Per-sprite pixel hit test against the prefetched row of the current line.
module sprite_hit_unit #(
    parameter int unsigned SPR_W   = 12,
    parameter int unsigned COORD_W = 8
) (
    input  logic [COORD_W-1:0] x,
    input  logic [SPR_W-1:0]   row,
    input  logic [COORD_W-1:0] pix_x,
    input  logic               pix_valid,
    output logic               hit
);

    logic [COORD_W-1:0] dx;
    logic [SPR_W-1:0]   shifted;

    // Modular distance so sprites straddling the coordinate wrap still render
    assign dx = pix_x - x;

    // Shifting left by dx brings row[SPR_W-1-dx] into the MSB (MSB = leftmost pixel)
    assign shifted = row << dx;

    assign hit = pix_valid && (32'(dx) < SPR_W) && shifted[SPR_W-1];

endmodule

// File: rtl/tqvp_sprite_engine_n.sv
// Multi-sprite line renderer: register file, pattern store, per-line row prefetch and
// priority-resolved pixel output with collision detection.
module tqvp_sprite_engine_n #(
    parameter int unsigned NUM_SPRITES = 3,
    parameter int unsigned SPR_W       = 12,
    parameter int unsigned SPR_H       = 12,
    parameter int unsigned COORD_W     = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [5:0]         address,
    input  logic [31:0]        data_in,
    input  logic [1:0]         data_write_n,
    input  logic [1:0]         data_read_n,
    output logic [31:0]        data_out,
    output logic               data_ready,
    input  logic               line_start,
    input  logic [COORD_W-1:0] line_y,
    input  logic               pix_valid,
    input  logic [COORD_W-1:0] pix_x,
    output logic               pix_on,
    output logic [2:0]         pix_id,
    output logic [3:0]         pix_colour,
    output logic               busy,
    output logic               user_interrupt
);
    import tqvp_sprite_pkg::*;

    // Register state
    logic                   ctrl_enable_q;
    logic                   ctrl_irq_en_q;
    logic [NUM_SPRITES-1:0] spr_mask_q;
    logic                   sticky_q;
    logic [3:0]             ptr_row_q, ptr_row_d;
    logic [2:0]             ptr_id_q, ptr_id_d;
    logic [SPR_W-1:0]       pat_q [NUM_SPRITES][SPR_H];
    logic [COORD_W-1:0]     spr_x_q [NUM_SPRITES];
    logic [COORD_W-1:0]     spr_y_q [NUM_SPRITES];
    logic [3:0]             spr_col_q [NUM_SPRITES];

    // Prefetch state
    scan_state_e            state_q, state_d;
    logic [2:0]             scan_idx_q, scan_idx_d;
    logic [COORD_W-1:0]     scan_y_q, scan_y_d;
    logic [SPR_W-1:0]       pending_q [NUM_SPRITES];
    logic [SPR_W-1:0]       active_q [NUM_SPRITES];

    // Bus decode
    logic                   wr_en;
    logic                   rd_en;
    logic [3:0]             spr_sel;
    logic                   spr_addr_ok;
    logic                   ptr_ok;
    logic                   pat_wr;
    logic                   status_clr;
    logic [SPR_W-1:0]       pat_rd;
    logic [31:0]            rd_data;
    logic                   unused_data;

    // Scan and pixel path
    logic [COORD_W-1:0]     scan_dy;
    logic                   scan_en;
    logic [SPR_W-1:0]       scan_row;
    logic                   commit;
    logic [NUM_SPRITES-1:0] raw_hit;
    logic [NUM_SPRITES-1:0] hits;
    logic                   win_any;
    logic [2:0]             win_id;
    logic [3:0]             win_col;
    logic                   multi_hit;
    int unsigned            hit_cnt;

    assign wr_en      = (data_write_n == 2'b10);
    assign rd_en      = (data_read_n != 2'b11);
    assign data_ready = rd_en;
    assign spr_sel    = address[5:2] - ADDR_SPR_BASE[5:2];
    assign spr_addr_ok = (address[1:0] == 2'b00) && (address >= ADDR_SPR_BASE)
                         && (32'(spr_sel) < NUM_SPRITES);
    assign ptr_ok     = (32'(ptr_id_q) < NUM_SPRITES) && (32'(ptr_row_q) < SPR_H);
    assign pat_wr     = wr_en && (address == ADDR_PAT_DATA) && ptr_ok;
    assign status_clr = wr_en && (address == ADDR_STATUS) && data_in[STATUS_COLL_BIT];
    // Not every data_in bit maps to a register field
    assign unused_data = ^data_in;

    assign busy           = (state_q != StIdle);
    assign user_interrupt = sticky_q & ctrl_irq_en_q;
    assign data_out       = rd_en ? rd_data : 32'd0;

    // Pattern pointer: explicit load, or auto-advance row-major after each accepted write
    always_comb begin
        ptr_row_d = ptr_row_q;
        ptr_id_d  = ptr_id_q;
        if (wr_en && address == ADDR_PAT_PTR) begin
            ptr_row_d = data_in[PTR_ROW_LSB +: 4];
            ptr_id_d  = data_in[PTR_ID_LSB +: 3];
        end else if (pat_wr) begin
            if (32'(ptr_row_q) == SPR_H - 1) begin
                ptr_row_d = 4'd0;
                ptr_id_d  = (32'(ptr_id_q) == NUM_SPRITES - 1) ? 3'd0 : ptr_id_q + 3'd1;
            end else begin
                ptr_row_d = ptr_row_q + 4'd1;
            end
        end
    end

    // Control, pointer and collision-sticky registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ctrl_enable_q <= 1'b0;
            ctrl_irq_en_q <= 1'b0;
            spr_mask_q    <= '0;
            sticky_q      <= 1'b0;
            ptr_row_q     <= 4'd0;
            ptr_id_q      <= 3'd0;
        end else begin
            if (wr_en && address == ADDR_CTRL) begin
                ctrl_enable_q <= data_in[CTRL_ENABLE_BIT];
                ctrl_irq_en_q <= data_in[CTRL_IRQ_EN_BIT];
                spr_mask_q    <= data_in[CTRL_MASK_LSB +: NUM_SPRITES];
            end
            // A new collision takes precedence over a same-cycle clear
            if (multi_hit) begin
                sticky_q <= 1'b1;
            end else if (status_clr) begin
                sticky_q <= 1'b0;
            end
            ptr_row_q <= ptr_row_d;
            ptr_id_q  <= ptr_id_d;
        end
    end

    // Pattern store and per-sprite position/colour registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < NUM_SPRITES; i++) begin
                spr_x_q[i]   <= '0;
                spr_y_q[i]   <= '0;
                spr_col_q[i] <= 4'd0;
                for (int unsigned r = 0; r < SPR_H; r++) begin
                    pat_q[i][r] <= '0;
                end
            end
        end else begin
            for (int unsigned i = 0; i < NUM_SPRITES; i++) begin
                if (wr_en && spr_addr_ok && 32'(spr_sel) == i) begin
                    spr_x_q[i]   <= data_in[COORD_W-1:0];
                    spr_y_q[i]   <= data_in[SPR_Y_LSB +: COORD_W];
                    spr_col_q[i] <= data_in[SPR_COL_LSB +: 4];
                end
                for (int unsigned r = 0; r < SPR_H; r++) begin
                    if (pat_wr && 32'(ptr_id_q) == i && 32'(ptr_row_q) == r) begin
                        pat_q[i][r] <= data_in[SPR_W-1:0];
                    end
                end
            end
        end
    end

    // Pattern readback at the current pointer; out-of-range pointers read zero
    always_comb begin
        pat_rd = '0;
        for (int unsigned i = 0; i < NUM_SPRITES; i++) begin
            for (int unsigned r = 0; r < SPR_H; r++) begin
                if (32'(ptr_id_q) == i && 32'(ptr_row_q) == r) begin
                    pat_rd = pat_q[i][r];
                end
            end
        end
    end

    // Register read mux; unmapped addresses and absent sprites read zero
    always_comb begin
        rd_data = 32'd0;
        if (address == ADDR_CTRL) begin
            rd_data[CTRL_ENABLE_BIT]               = ctrl_enable_q;
            rd_data[CTRL_IRQ_EN_BIT]               = ctrl_irq_en_q;
            rd_data[CTRL_MASK_LSB +: NUM_SPRITES] = spr_mask_q;
        end else if (address == ADDR_STATUS) begin
            rd_data[STATUS_COLL_BIT] = sticky_q;
            rd_data[STATUS_BUSY_BIT] = busy;
        end else if (address == ADDR_PAT_PTR) begin
            rd_data[PTR_ROW_LSB +: 4] = ptr_row_q;
            rd_data[PTR_ID_LSB +: 3]  = ptr_id_q;
        end else if (address == ADDR_PAT_DATA) begin
            rd_data[SPR_W-1:0] = pat_rd;
        end else if (spr_addr_ok) begin
            for (int unsigned i = 0; i < NUM_SPRITES; i++) begin
                if (32'(spr_sel) == i) begin
                    rd_data[COORD_W-1:0]           = spr_x_q[i];
                    rd_data[SPR_Y_LSB +: COORD_W]  = spr_y_q[i];
                    rd_data[SPR_COL_LSB +: 4]      = spr_col_q[i];
                end
            end
        end
    end

    // Row lookup for the sprite currently being scanned
    always_comb begin
        scan_dy  = '0;
        scan_en  = 1'b0;
        scan_row = '0;
        for (int unsigned i = 0; i < NUM_SPRITES; i++) begin
            if (32'(scan_idx_q) == i) begin
                scan_dy = scan_y_q - spr_y_q[i];
                scan_en = spr_mask_q[i];
                for (int unsigned r = 0; r < SPR_H; r++) begin
                    if (32'(scan_dy) == r) begin
                        scan_row = pat_q[i][r];
                    end
                end
            end
        end
        if (!scan_en || 32'(scan_dy) >= SPR_H) begin
            scan_row = '0;
        end
    end

    // Prefetch FSM next state: a line_start always (re)starts the scan from sprite 0
    always_comb begin
        state_d    = state_q;
        scan_idx_d = scan_idx_q;
        scan_y_d   = scan_y_q;
        case (state_q)
            StIdle: ;
            StScan: begin
                if (32'(scan_idx_q) == NUM_SPRITES - 1) begin
                    state_d = StCommit;
                end else begin
                    scan_idx_d = scan_idx_q + 3'd1;
                end
            end
            StCommit: state_d = StIdle;
            default:  state_d = StIdle;
        endcase
        if (line_start) begin
            state_d    = StScan;
            scan_idx_d = 3'd0;
            scan_y_d   = line_y;
        end
    end

    // A restart arriving in COMMIT abandons the half-stale pending rows
    assign commit = (state_q == StCommit) && !line_start;

    // Prefetch FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            scan_idx_q <= 3'd0;
            scan_y_q   <= '0;
        end else begin
            state_q    <= state_d;
            scan_idx_q <= scan_idx_d;
            scan_y_q   <= scan_y_d;
        end
    end

    // Pending rows fill during SCAN; active rows swap in on COMMIT
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < NUM_SPRITES; i++) begin
                pending_q[i] <= '0;
                active_q[i]  <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < NUM_SPRITES; i++) begin
                if (state_q == StScan && 32'(scan_idx_q) == i) begin
                    pending_q[i] <= scan_row;
                end
                if (commit) begin
                    active_q[i] <= pending_q[i];
                end
            end
        end
    end

    for (genvar g = 0; g < NUM_SPRITES; g++) begin : g_hit
        sprite_hit_unit #(
            .SPR_W   (SPR_W),
            .COORD_W (COORD_W)
        ) u_hit (
            .x         (spr_x_q[g]),
            .row       (active_q[g]),
            .pix_x     (pix_x),
            .pix_valid (pix_valid),
            .hit       (raw_hit[g])
        );
    end

    assign hits = raw_hit & {NUM_SPRITES{ctrl_enable_q}};

    // Lowest-index priority and collision count
    always_comb begin
        win_any = 1'b0;
        win_id  = 3'd0;
        win_col = 4'd0;
        hit_cnt = 0;
        for (int unsigned i = 0; i < NUM_SPRITES; i++) begin
            if (hits[i]) begin
                hit_cnt = hit_cnt + 1;
                if (!win_any) begin
                    win_any = 1'b1;
                    win_id  = 3'(i);
                    win_col = spr_col_q[i];
                end
            end
        end
        multi_hit = (hit_cnt >= 2);
    end

    // Registered pixel outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pix_on     <= 1'b0;
            pix_id     <= 3'd0;
            pix_colour <= 4'd0;
        end else begin
            pix_on     <= win_any;
            pix_id     <= win_id;
            pix_colour <= win_col;
        end
    end

endmodule

// File: tb/tb_tqvp_sprite_engine_n.sv
// Directed self-checking bench for tqvp_sprite_engine_n at default parameters.
module tb_tqvp_sprite_engine_n;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  address;
    logic [31:0] data_in;
    logic [1:0]  data_write_n;
    logic [1:0]  data_read_n;
    logic [31:0] data_out;
    logic        data_ready;
    logic        line_start;
    logic [7:0]  line_y;
    logic        pix_valid;
    logic [7:0]  pix_x;
    logic        pix_on;
    logic [2:0]  pix_id;
    logic [3:0]  pix_colour;
    logic        busy;
    logic        user_interrupt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    tqvp_sprite_engine_n #(
        .NUM_SPRITES (3),
        .SPR_W       (12),
        .SPR_H       (12),
        .COORD_W     (8)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .address        (address),
        .data_in        (data_in),
        .data_write_n   (data_write_n),
        .data_read_n    (data_read_n),
        .data_out       (data_out),
        .data_ready     (data_ready),
        .line_start     (line_start),
        .line_y         (line_y),
        .pix_valid      (pix_valid),
        .pix_x          (pix_x),
        .pix_on         (pix_on),
        .pix_id         (pix_id),
        .pix_colour     (pix_colour),
        .busy           (busy),
        .user_interrupt (user_interrupt)
    );

    task automatic bus_write(input logic [5:0] a, input logic [31:0] d);
        @(negedge clk);
        address = a; data_in = d; data_write_n = 2'b10;
        @(negedge clk);
        data_write_n = 2'b11;
    endtask

    task automatic bus_read(input logic [5:0] a, output logic [31:0] d);
        @(negedge clk);
        address = a; data_read_n = 2'b00;
        #1;
        d = data_out;
        data_read_n = 2'b11;
    endtask

    task automatic start_line(input logic [7:0] y);
        @(negedge clk);
        line_start = 1'b1; line_y = y;
        @(negedge clk);
        line_start = 1'b0;
        repeat (5) @(negedge clk);
    endtask

    // Drive one valid pixel; returns at the negedge where its registered result is visible
    task automatic pixel(input logic [7:0] x);
        @(negedge clk);
        pix_x = x; pix_valid = 1'b1;
        @(negedge clk);
        pix_valid = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] d;
        #2;
        checks++;
        if (pix_on !== 1'b0 || pix_id !== 3'd0 || pix_colour !== 4'd0 || busy !== 1'b0
            || user_interrupt !== 1'b0 || data_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: on=%b id=%0d col=%0d busy=%b irq=%b rdy=%b, want all 0",
                     pix_on, pix_id, pix_colour, busy, user_interrupt, data_ready);
        end
        address = 6'h00; data_read_n = 2'b00; #1;
        checks++;
        if (data_ready !== 1'b1 || data_out !== 32'd0) begin
            errors++;
            $display("FAIL reset_read: rdy=%b data=%h, want 1 00000000", data_ready, data_out);
        end
        data_read_n = 2'b11;
        @(negedge clk); rst = 1'b0;
        bus_read(6'h04, d);
        checks++;
        if (d !== 32'd0) begin
            errors++; $display("FAIL reset_status: got %h want 00000000", d);
        end
    endtask

    task automatic test_basic();
        logic [31:0] d;
        bus_write(6'h08, 32'h000);
        bus_write(6'h0C, 32'h800);
        bus_write(6'h10, 32'h5014_000A);
        bus_write(6'h00, 32'h0000_0101);
        bus_read(6'h10, d);
        checks++;
        if (d !== 32'h5014_000A) begin
            errors++; $display("FAIL spr0_readback: got %h want 5014000a", d);
        end
        start_line(8'd20);
        pixel(8'd10);
        checks++;
        if (pix_on !== 1'b1 || pix_id !== 3'd0 || pix_colour !== 4'd5) begin
            errors++;
            $display("FAIL basic_hit: on=%b id=%0d col=%0d, want 1 0 5", pix_on, pix_id, pix_colour);
        end
        pixel(8'd11);
        checks++;
        if (pix_on !== 1'b0 || pix_colour !== 4'd0) begin
            errors++; $display("FAIL basic_miss: on=%b col=%0d, want 0 0", pix_on, pix_colour);
        end
        bus_write(6'h00, 32'h0000_FF01);
        bus_read(6'h00, d);
        checks++;
        if (d !== 32'h0000_0701) begin
            errors++; $display("FAIL ctrl_mask_width: got %h want 00000701", d);
        end
        bus_read(6'h1C, d);
        checks++;
        if (d !== 32'd0) begin
            errors++; $display("FAIL absent_sprite_read: got %h want 00000000", d);
        end
        bus_write(6'h00, 32'h0000_0101);
    endtask

    task automatic test_busy_timing();
        logic [31:0] d;
        int cnt;
        @(negedge clk);
        line_start = 1'b1; line_y = 8'd20;
        @(negedge clk);
        line_start = 1'b0;
        cnt = 0;
        for (int k = 0; k < 10; k++) begin
            if (busy === 1'b1) cnt++;
            @(negedge clk);
        end
        checks++;
        if (cnt != 4) begin
            errors++; $display("FAIL busy_cycles: got %0d want 4", cnt);
        end
        @(negedge clk);
        line_start = 1'b1; line_y = 8'd20;
        @(negedge clk);
        line_start = 1'b0;
        bus_read(6'h04, d);
        checks++;
        if (d !== 32'h2) begin
            errors++; $display("FAIL status_busy: got %h want 00000002", d);
        end
        repeat (5) @(negedge clk);
        start_line(8'd32);
        pixel(8'd10);
        checks++;
        if (pix_on !== 1'b0) begin
            errors++; $display("FAIL dy_beyond_height: on=%b want 0", pix_on);
        end
    endtask

    task automatic test_collision();
        logic [31:0] d;
        bus_write(6'h08, 32'h100);
        bus_write(6'h0C, 32'h800);
        bus_write(6'h14, 32'h9014_000A);
        bus_write(6'h00, 32'h0000_0303);
        start_line(8'd20);
        pixel(8'd10);
        checks++;
        if (pix_on !== 1'b1 || pix_id !== 3'd0 || pix_colour !== 4'd5) begin
            errors++;
            $display("FAIL overlap_priority: on=%b id=%0d col=%0d, want 1 0 5",
                     pix_on, pix_id, pix_colour);
        end
        @(negedge clk);
        checks++;
        if (user_interrupt !== 1'b1) begin
            errors++; $display("FAIL collision_irq: got %b want 1", user_interrupt);
        end
        bus_write(6'h04, 32'h1);
        bus_read(6'h04, d);
        checks++;
        if (d !== 32'h0 || user_interrupt !== 1'b0) begin
            errors++; $display("FAIL status_clear: status=%h irq=%b, want 00000000 0", d, user_interrupt);
        end
        @(negedge clk);
        address = 6'h04; data_in = 32'h1; data_write_n = 2'b10; pix_x = 8'd10; pix_valid = 1'b1;
        @(negedge clk);
        data_write_n = 2'b11; pix_valid = 1'b0;
        bus_read(6'h04, d);
        checks++;
        if (d !== 32'h1) begin
            errors++; $display("FAIL set_beats_clear: got %h want 00000001", d);
        end
        bus_write(6'h04, 32'h1);
        bus_write(6'h00, 32'h0000_0203);
        start_line(8'd20);
        pixel(8'd10);
        checks++;
        if (pix_on !== 1'b1 || pix_id !== 3'd1 || pix_colour !== 4'd9) begin
            errors++;
            $display("FAIL masked_sprite0: on=%b id=%0d col=%0d, want 1 1 9", pix_on, pix_id, pix_colour);
        end
        bus_read(6'h04, d);
        checks++;
        if (d !== 32'h0) begin
            errors++; $display("FAIL single_hit_no_collision: got %h want 00000000", d);
        end
        bus_write(6'h00, 32'h0000_0302);
        start_line(8'd20);
        pixel(8'd10);
        bus_read(6'h04, d);
        checks++;
        if (pix_on !== 1'b0 || d !== 32'h0) begin
            errors++; $display("FAIL disabled: on=%b status=%h, want 0 00000000", pix_on, d);
        end
        bus_write(6'h00, 32'h0000_0303);
        pixel(8'd10);
        checks++;
        if (pix_on !== 1'b1 || pix_id !== 3'd0) begin
            errors++;
            $display("FAIL prefetch_while_disabled: on=%b id=%0d, want 1 0", pix_on, pix_id);
        end
        bus_write(6'h04, 32'h1);
    endtask

    task automatic test_pointer();
        logic [31:0] d;
        bus_write(6'h08, 32'h00B);
        bus_write(6'h0C, 32'hFFFF_F123);
        bus_write(6'h0C, 32'h456);
        bus_read(6'h08, d);
        checks++;
        if (d !== 32'h101) begin
            errors++; $display("FAIL ptr_advance: got %h want 00000101", d);
        end
        bus_write(6'h08, 32'h100);
        bus_read(6'h0C, d);
        checks++;
        if (d !== 32'h456) begin
            errors++; $display("FAIL pat_row_wrap: got %h want 00000456", d);
        end
        bus_read(6'h08, d);
        checks++;
        if (d !== 32'h100) begin
            errors++; $display("FAIL read_no_advance: got %h want 00000100", d);
        end
        bus_write(6'h08, 32'h00B);
        bus_read(6'h0C, d);
        checks++;
        if (d !== 32'h123) begin
            errors++; $display("FAIL pat_width_mask: got %h want 00000123", d);
        end
        bus_write(6'h08, 32'h20B);
        bus_write(6'h0C, 32'hAAA);
        bus_read(6'h08, d);
        checks++;
        if (d !== 32'h000) begin
            errors++; $display("FAIL ptr_id_wrap: got %h want 00000000", d);
        end
        bus_write(6'h08, 32'h300);
        bus_write(6'h0C, 32'hFFF);
        bus_read(6'h08, d);
        checks++;
        if (d !== 32'h300) begin
            errors++; $display("FAIL ptr_oob_held: got %h want 00000300", d);
        end
        bus_read(6'h0C, d);
        checks++;
        if (d !== 32'h0) begin
            errors++; $display("FAIL pat_oob_read: got %h want 00000000", d);
        end
        bus_write(6'h00, 32'h0000_0101);
        start_line(8'd31);
        pixel(8'd13);
        checks++;
        if (pix_on !== 1'b1) begin
            errors++; $display("FAIL last_row_dx3: on=%b want 1", pix_on);
        end
        pixel(8'd14);
        checks++;
        if (pix_on !== 1'b0) begin
            errors++; $display("FAIL last_row_dx4: on=%b want 0", pix_on);
        end
        pixel(8'd21);
        checks++;
        if (pix_on !== 1'b1) begin
            errors++; $display("FAIL last_col_dx11: on=%b want 1", pix_on);
        end
        pixel(8'd22);
        checks++;
        if (pix_on !== 1'b0) begin
            errors++; $display("FAIL past_width_dx12: on=%b want 0", pix_on);
        end
    endtask

    task automatic test_wrap();
        bus_write(6'h08, 32'h000);
        bus_write(6'h0C, 32'h008);
        bus_write(6'h10, 32'h5014_00FA);
        start_line(8'd20);
        pixel(8'd2);
        checks++;
        if (pix_on !== 1'b1 || pix_colour !== 4'd5) begin
            errors++; $display("FAIL x_wrap_hit: on=%b col=%0d, want 1 5", pix_on, pix_colour);
        end
        pixel(8'd3);
        checks++;
        if (pix_on !== 1'b0) begin
            errors++; $display("FAIL x_wrap_miss: on=%b want 0", pix_on);
        end
        pixel(8'd250);
        checks++;
        if (pix_on !== 1'b0) begin
            errors++; $display("FAIL x_wrap_dx0: on=%b want 0", pix_on);
        end
    endtask

    task automatic test_restart();
        int cnt;
        @(negedge clk);
        line_start = 1'b1; line_y = 8'd20;
        @(negedge clk);
        line_y = 8'd32;
        @(negedge clk);
        line_start = 1'b0;
        cnt = 0;
        for (int k = 0; k < 10; k++) begin
            if (busy === 1'b1) cnt++;
            @(negedge clk);
        end
        checks++;
        if (cnt != 4) begin
            errors++; $display("FAIL restart_busy: got %0d want 4", cnt);
        end
        pixel(8'd2);
        checks++;
        if (pix_on !== 1'b0) begin
            errors++; $display("FAIL restart_new_y: on=%b want 0", pix_on);
        end
        start_line(8'd20);
        pixel(8'd2);
        checks++;
        if (pix_on !== 1'b1) begin
            errors++; $display("FAIL restart_recover: on=%b want 1", pix_on);
        end
    endtask

    task automatic test_reset_mid_scan();
        logic [31:0] d;
        @(negedge clk);
        pix_x = 8'd2; pix_valid = 1'b1; line_start = 1'b1; line_y = 8'd20;
        @(negedge clk);
        line_start = 1'b0;
        checks++;
        if (busy !== 1'b1 || pix_on !== 1'b1) begin
            errors++; $display("FAIL pre_reset: busy=%b on=%b, want 1 1", busy, pix_on);
        end
        #1 rst = 1'b1;
        #1;
        checks++;
        if (busy !== 1'b0 || pix_on !== 1'b0 || pix_colour !== 4'd0) begin
            errors++;
            $display("FAIL async_reset: busy=%b on=%b col=%0d, want 0 0 0", busy, pix_on, pix_colour);
        end
        @(negedge clk);
        pix_valid = 1'b0; rst = 1'b0;
        bus_read(6'h00, d);
        checks++;
        if (d !== 32'd0) begin
            errors++; $display("FAIL reset_ctrl: got %h want 00000000", d);
        end
        bus_read(6'h10, d);
        checks++;
        if (d !== 32'd0) begin
            errors++; $display("FAIL reset_spr0: got %h want 00000000", d);
        end
        bus_write(6'h00, 32'h0000_0101);
        pixel(8'd0);
        checks++;
        if (pix_on !== 1'b0) begin
            errors++; $display("FAIL reset_active_rows: on=%b want 0", pix_on);
        end
    endtask

    initial begin
        rst = 1'b1;
        address = 6'h00; data_in = 32'd0; data_write_n = 2'b11; data_read_n = 2'b11;
        line_start = 1'b0; line_y = 8'd0; pix_valid = 1'b0; pix_x = 8'd0;
        test_reset();
        test_basic();
        test_busy_timing();
        test_collision();
        test_pointer();
        test_wrap();
        test_restart();
        test_reset_mid_scan();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1);
    end

endmodule
